// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  localparam int unsigned PC_W   = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_HOLD   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_FETCH  = 2'b01,
    S_HOLD   = 2'b10,
    S_UPDATE = 2'b11
  } pc_state_e;

  // jalr targets have bit 0 cleared before any further alignment handling
  function automatic logic [PC_W-1:0] jalr_clear(input logic [PC_W-1:0] target,
                                                 input pc_sel_e sel);
    jalr_clear = (sel == PC_JALR) ? (target & ~PC_W'(1)) : target;
  endfunction

endpackage

// File: rtl/pc_operand_mux.sv
// Adder operand steering: selects PC/rs1 and 4/imm/0 from the PC source select.
module pc_operand_mux
  import pc_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  pc_sel_e          sel,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1_val,
  output logic [XLEN-1:0]  add_in1,
  output logic [XLEN-1:0]  add_in2
);

  // Operand select; a not-taken branch degenerates to sequential PC+4
  always_comb begin
    add_in1 = pc;
    add_in2 = XLEN'(PC_INC);
    case (sel)
      PC_SEQ:    add_in2 = XLEN'(PC_INC);
      PC_BRANCH: add_in2 = branch_taken ? imm : XLEN'(PC_INC);
      PC_JALR: begin
        add_in1 = rs1_val;
        add_in2 = imm;
      end
      PC_HOLD:   add_in2 = '0;
      default:   add_in2 = XLEN'(PC_INC);
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: holds PC, runs the instruction fetch handshake and
// commits the external Adder result as the next PC on microcode command.
// Optional macro PC_MISALIGN_CHECK_EN: refuses targets with bit 1 set and
// raises a sticky misalign_err instead of force-aligning the target.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_start,
  input  logic             pc_update,
  input  logic [1:0]       pc_sel,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1_val,
  output logic [XLEN-1:0]  add_in1,
  output logic [XLEN-1:0]  add_in2,
  input  logic [XLEN-1:0]  add_out,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  instr,
  output logic             instr_valid,
  output logic [XLEN-1:0]  pc,
  output logic             busy
`ifdef PC_MISALIGN_CHECK_EN
  ,
  output logic             misalign_err
`endif
);

  pc_state_e       state_q, state_d;
  pc_sel_e         sel_q, sel_d, mux_sel;
  logic            taken_q, taken_d, mux_taken;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] target;
  logic            instr_valid_q, instr_valid_d;
  logic            imem_req_q, imem_req_d;
  logic            busy_q, busy_d;
  logic            accept_upd;
`ifdef PC_MISALIGN_CHECK_EN
  logic            err_q, err_d;
`endif

  // Select and taken flag are captured with the update strobe and replayed in UPDATE
  assign accept_upd = pc_update && ((state_q == S_IDLE) || (state_q == S_HOLD));
  assign mux_sel    = (state_q == S_UPDATE) ? sel_q : pc_sel_e'(pc_sel);
  assign mux_taken  = (state_q == S_UPDATE) ? taken_q : branch_taken;

  pc_operand_mux #(.XLEN(XLEN)) u_operand_mux (
    .sel          (mux_sel),
    .branch_taken (mux_taken),
    .pc           (pc_q),
    .imm          (imm),
    .rs1_val      (rs1_val),
    .add_in1      (add_in1),
    .add_in2      (add_in2)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: update beats fetch; FETCH waits on memory and ignores strobes
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (pc_update)        state_d = S_UPDATE;
        else if (fetch_start) state_d = S_FETCH;
      end
      S_FETCH:  if (imem_ready) state_d = S_HOLD;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values
  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    sel_d         = sel_q;
    taken_d       = taken_q;
    imem_req_d    = (state_d == S_FETCH);
    busy_d        = (state_d == S_FETCH) || (state_d == S_UPDATE);
    target        = jalr_clear(add_out, sel_q);
`ifdef PC_MISALIGN_CHECK_EN
    err_d         = err_q;
`endif
    if (accept_upd) begin
      sel_d   = pc_sel_e'(pc_sel);
      taken_d = branch_taken;
    end
    if ((state_q == S_FETCH) && imem_ready) begin
      instr_d       = imem_rdata;
      instr_valid_d = 1'b1;
    end
    if (state_q == S_UPDATE) begin
      instr_valid_d = 1'b0;
      if (sel_q != PC_HOLD) begin
`ifdef PC_MISALIGN_CHECK_EN
        if (target[1]) err_d = 1'b1;
        else           pc_d  = target & ~XLEN'(3);
`else
        pc_d = target & ~XLEN'(3);
`endif
      end
    end
  end

  // Datapath and output registers; async reset drops imem_req immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= XLEN'(RESET_PC);
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      busy_q        <= 1'b0;
      sel_q         <= PC_SEQ;
      taken_q       <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
      err_q         <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      busy_q        <= busy_d;
      sel_q         <= sel_d;
      taken_q       <= taken_d;
`ifdef PC_MISALIGN_CHECK_EN
      err_q         <= err_d;
`endif
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = imem_req_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;
`ifdef PC_MISALIGN_CHECK_EN
  assign misalign_err = err_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized fetch/update
// traffic against a behavioural PC/instruction model. Honours PC_MISALIGN_CHECK_EN.
`timescale 1ns/1ps
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic        pc_update = 1'b0;
  logic [1:0]  pc_sel = 2'd0;
  logic        branch_taken = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] add_in1, add_in2, add_out;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        busy;
`ifdef PC_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic        m_valid = 1'b0;
  logic        m_err   = 1'b0;

  // External 32-bit Adder sitting next to the block
  assign add_out = add_in1 + add_in2;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_start  (fetch_start),
    .pc_update    (pc_update),
    .pc_sel       (pc_sel),
    .branch_taken (branch_taken),
    .imm          (imm),
    .rs1_val      (rs1_val),
    .add_in1      (add_in1),
    .add_in2      (add_in2),
    .add_out      (add_out),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .busy         (busy)
`ifdef PC_MISALIGN_CHECK_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_err(input string tag);
`ifdef PC_MISALIGN_CHECK_EN
    chk(tag, 32'(misalign_err), 32'(m_err));
`else
    if (m_err) chk(tag, 32'd1, 32'd0);
`endif
  endtask

  // Unaligned target from the architectural rules (before alignment handling)
  function automatic logic [31:0] raw_target(input logic [1:0] sel, input logic taken,
                                             input logic [31:0] cur, input logic [31:0] im,
                                             input logic [31:0] r1);
    case (sel)
      2'd0:    return cur + 32'd4;
      2'd1:    return taken ? cur + im : cur + 32'd4;
      2'd2:    return (r1 + im) & 32'hFFFF_FFFE;
      default: return cur;
    endcase
  endfunction

  task automatic chk_mux(input logic [1:0] sel, input logic taken,
                         input logic [31:0] im, input logic [31:0] r1);
    logic [31:0] e1, e2;
    pc_sel = sel; branch_taken = taken; imm = im; rs1_val = r1;
    #1;
    e1 = (sel == 2'd2) ? r1 : m_pc;
    case (sel)
      2'd0:    e2 = 32'd4;
      2'd1:    e2 = taken ? im : 32'd4;
      2'd2:    e2 = im;
      default: e2 = 32'd0;
    endcase
    chk("mux_in1", add_in1, e1);
    chk("mux_in2", add_in2, e2);
  endtask

  task automatic do_fetch(input logic [31:0] word, input int waits);
    fetch_start = 1'b1; imem_ready = 1'b0; imem_rdata = $urandom;
    tick();
    fetch_start = 1'b0;
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_busy", 32'(busy), 32'd1);
    chk("fetch_valid_early", 32'(instr_valid), 32'(m_valid));
    for (int i = 0; i < waits; i++) begin
      pc_update = 1'b1; fetch_start = 1'($urandom_range(0, 1));
      pc_sel = 2'($urandom_range(0, 3)); imem_rdata = $urandom;
      tick();
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_pc", pc, m_pc);
      chk("wait_valid", 32'(instr_valid), 32'(m_valid));
    end
    pc_update = 1'b0; fetch_start = 1'b0; imem_ready = 1'b1; imem_rdata = word;
    tick();
    imem_ready = 1'b0;
    m_instr = word; m_valid = 1'b1;
    chk("fetch_instr", instr, m_instr);
    chk("fetch_valid", 32'(instr_valid), 32'd1);
    chk("fetch_req_drop", 32'(imem_req), 32'd0);
    chk("fetch_busy_drop", 32'(busy), 32'd0);
  endtask

  task automatic do_update(input logic [1:0] sel, input logic taken, input logic [31:0] im,
                           input logic [31:0] r1, input logic both);
    logic [31:0] t;
    pc_update = 1'b1; fetch_start = both;
    pc_sel = sel; branch_taken = taken; imm = im; rs1_val = r1;
    tick();
    pc_update = 1'b0; fetch_start = 1'b0;
    chk("upd_busy", 32'(busy), 32'd1);
    chk("upd_req", 32'(imem_req), 32'd0);
    chk("upd_pc_old", pc, m_pc);
    tick();
    t = raw_target(sel, taken, m_pc, im, r1);
    if (sel != 2'd3) begin
`ifdef PC_MISALIGN_CHECK_EN
      if (t[1]) m_err = 1'b1;
      else      m_pc  = t & 32'hFFFF_FFFC;
`else
      m_pc = t & 32'hFFFF_FFFC;
`endif
    end
    m_valid = 1'b0;
    chk("upd_pc", pc, m_pc);
    chk("upd_valid", 32'(instr_valid), 32'd0);
    chk("upd_busy_drop", 32'(busy), 32'd0);
    chk("upd_req_idle", 32'(imem_req), 32'd0);
    chk_err("upd_err");
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_err("rst_err");
    #2 rst_n = 1'b1;
    tick();

    // First fetch at zero-wait, then sequential update
    do_fetch(32'h0000_0013, 0);
    tick();
    chk("hold_instr", instr, m_instr);
    chk("hold_valid", 32'(instr_valid), 32'd1);
    do_update(2'd0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Operand steering in IDLE
    chk_mux(2'd0, 1'b0, 32'h0000_0040, 32'h1234_5678);
    chk_mux(2'd1, 1'b1, 32'hFFFF_FFF8, 32'h1234_5678);
    chk_mux(2'd1, 1'b0, 32'hFFFF_FFF8, 32'h1234_5678);
    chk_mux(2'd2, 1'b0, 32'h0000_0010, 32'h0000_2001);
    chk_mux(2'd3, 1'b1, 32'h0000_0010, 32'h0000_2001);

    // Branch taken / not taken from 0x100
    do_update(2'd2, 1'b0, 32'h0, 32'h0000_0100, 1'b0);
    do_update(2'd1, 1'b1, 32'hFFFF_FFF8, 32'h0, 1'b0);
    chk("branch_taken_pc", pc, 32'h0000_00F8);
    do_update(2'd2, 1'b0, 32'h0, 32'h0000_0100, 1'b0);
    do_update(2'd1, 1'b0, 32'hFFFF_FFF8, 32'h0, 1'b0);
    chk("branch_not_taken_pc", pc, 32'h0000_0104);

    // jalr clears bit 0
    do_update(2'd2, 1'b0, 32'h0000_0010, 32'h0000_2001, 1'b0);
    chk("jalr_pc", pc, 32'h0000_2010);

    // Hold keeps PC; simultaneous strobes let the update win
    do_update(2'd3, 1'b0, 32'h0, 32'h0, 1'b1);
    do_update(2'd0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Five wait states with pc_update noise, then refetch from HOLD
    do_fetch(32'hDEAD_BEEF, 5);
    do_fetch(32'h0040_0093, 2);

    // Wrap-around
    do_update(2'd2, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0);
    do_update(2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("wrap_pc", pc, 32'h0);

    // Misaligned branch target then a normal step
    do_update(2'd2, 1'b0, 32'h0, 32'h0000_0100, 1'b0);
    do_update(2'd1, 1'b1, 32'h0000_0006, 32'h0, 1'b0);
    do_update(2'd0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Reset asserted mid-FETCH
    fetch_start = 1'b1; imem_ready = 1'b0;
    tick();
    fetch_start = 1'b0;
    chk("midrst_req_before", 32'(imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_pc", pc, m_pc);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk_err("midrst_err");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Randomized fetch/update traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0)
        do_fetch($urandom, int'($urandom_range(0, 3)));
      else
        do_update(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom & 32'hFFFF_FFFE, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage of the non-pipelined microprogrammed RV32I core; sits directly upstream of the 32-bit signed Adder.
- Holds the PC and drives the instruction-memory fetch handshake.
- Each instruction, it steers the Adder operands (PC+4, PC+imm, rs1+imm) and latches the Adder result as the next PC when microcode commands an update.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- fetch_start  in  1  microcode strobe: begin fetch at current PC
- pc_update  in  1  microcode strobe: commit next PC
- pc_sel  in  2  00 seq (PC+4), 01 branch (PC+imm if branch_taken else PC+4), 10 jalr (rs1+imm), 11 hold
- branch_taken  in  1  comparator result, sampled with pc_update
- imm  in  32  signed immediate
- rs1_val  in  32  register rs1 value
- add_in1  out  32  Adder operand A (combinational)
- add_in2  out  32  Adder operand B (combinational)
- add_out  in  32  Adder result
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, equals pc
- imem_ready  in  1  memory accepts the request and returns data this cycle
- imem_rdata  in  32  instruction word
- instr  out  32  latched instruction
- instr_valid  out  1  instr holds a fetched word
- pc  out  32  current PC
- busy  out  1  high in FETCH or UPDATE

Behaviour:
- Reset (asynchronous, rst_n low):
  - pc=RESET_PC, state=IDLE, instr=0.
  - instr_valid=0, imem_req=0, busy=0, misalign_err=0.
- Operand mux:
  - seq: add_in1=pc, add_in2=32'd4.
  - branch: add_in1=pc, add_in2 = branch_taken ? imm : 4.
  - jalr: add_in1=rs1_val, add_in2=imm.
  - hold: add_in1=pc, add_in2=0.
- FSM states: IDLE, FETCH, HOLD, UPDATE.
- IDLE:
  - fetch_start -> FETCH.
  - pc_update -> UPDATE.
  - Both asserted: pc_update wins, fetch_start is dropped.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready: instr<=imem_rdata, instr_valid<=1, -> HOLD.
  - Without imem_ready: stay indefinitely; pc_update and fetch_start are ignored.
  - Minimum latency from fetch_start to instr_valid: 2 cycles (zero-wait memory).
- HOLD:
  - instr and instr_valid stable.
  - pc_update -> UPDATE.
  - fetch_start -> FETCH (refetch same PC; instr_valid stays 1 until the new word lands).
- UPDATE (one cycle):
  - pc <= add_out; for jalr, pc <= add_out & ~32'h1.
  - hold: pc unchanged.
  - instr_valid<=0, then -> IDLE.
  - Next PC is visible on pc the cycle after UPDATE.
- Arithmetic: wrap-around modulo 2^32 is legal (PC=32'hFFFF_FFFC, seq -> 0); no overflow flag.
- Reset mid-FETCH: imem_req drops immediately (asynchronously).

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- When defined:
  - Adds output misalign_err (1 bit, sticky).
  - In UPDATE, if the computed target bit[1] is 1 (after the jalr bit-0 clear), pc is NOT updated, misalign_err<=1, FSM -> IDLE.
  - misalign_err is cleared only by reset.
- When undefined:
  - No misalign_err port.
  - Target is always loaded, with bits [1:0] forced to 0.

Decomposition:
- Package pc_seq_pkg:
  - enum pc_sel_e {PC_SEQ, PC_BRANCH, PC_JALR, PC_HOLD}
  - enum pc_state_e {S_IDLE, S_FETCH, S_HOLD, S_UPDATE}
  - localparam PC_INC = 32'd4
- Sub-module pc_operand_mux: purely combinational pc_sel -> add_in1/add_in2.
- The Adder is instantiated externally, next to this block.

Test Plan:
- Reset release, fetch_start with imem_ready=1 -> imem_addr=0, instr=imem_rdata, instr_valid=1 two cycles after the strobe; then pc_update seq -> pc=4.
- pc=0x100, pc_sel=branch, imm=-8, branch_taken=1 -> pc=0xF8. Same stimulus with branch_taken=0 -> pc=0x104.
- jalr, rs1_val=0x2001, imm=0x10 -> pc=0x2010 (bit 0 cleared).
- imem_ready low 5 cycles during FETCH with pc_update pulsed -> imem_req held 5 cycles, pc unchanged, word latched on the 6th cycle.
- pc=0xFFFF_FFFC, seq update -> pc=0. Assert rst_n low mid-FETCH -> imem_req=0 immediately, pc=RESET_PC.
- PC_MISALIGN_CHECK_EN defined, branch imm=6 from pc=0x100 -> pc stays 0x100, misalign_err=1 and persists until reset.
